traffic_gen_checker: RTL
========================

// Module: traffic_gen_checker
// PURPOSE
//  Synthesizable, parametrised traffic source/sink for the interconnect device (main FIFO -> VCs -> D0..Dn).
//  Pushes a programmable word stream into the main FIFO input and honours MAIN_FIFO pause.
//  Pops every destination FIFO that is not almost-empty.
//  Compares the behavioural and synthesized DUT outputs lane by lane and counts pushes and mismatches.
// PARAMETERS
//  DATA_W     6        word width of data_out and of each destination lane
//  N_DEST     2        number of destination FIFOs (pop/almost_empty/compare lanes)
//  CNT_W      16       width of num_words, sent_count, mismatch_count
//  DRAIN_CYC  50       cycles spent in DRAIN after the last push
//  LFSR_TAPS  6'h30    Fibonacci feedback mask, DATA_W bits (default x^6+x^5+1)
// PORTS
//  clk             in   1               rising-edge clock
//  reset           in   1               synchronous, active-high reset
//  start           in   1               1-cycle pulse; accepted only in IDLE or DONE
//  mode            in   2               0=incr, 1=LFSR, 2=constant, 3=incr with MSB toggled each word
//  seed            in   DATA_W          first word / LFSR seed, latched on start
//  num_words       in   CNT_W           words to push per run; 0 => straight to DRAIN
//  pause_in        in   1               MAIN_FIFO_pause from the DUT
//  data_out        out  DATA_W          word to the DUT data_in
//  push_out        out  1               push to the DUT push_data_in
//  almost_empty_in in   N_DEST          destination almost-empty flags
//  pop_out         out  N_DEST          destination pops
//  data_a          in   N_DEST*DATA_W   behavioural DUT outputs, lane i = [i*DATA_W +: DATA_W]
//  data_b          in   N_DEST*DATA_W   synthesized DUT outputs, same packing
//  busy            out  1               1 in GEN or DRAIN
//  done            out  1               1 in DONE
//  sent_count      out  CNT_W           pushes issued this run
//  mismatch_count  out  CNT_W           lane mismatches this run; saturates at all-ones
//  err_flag        out  1               sticky: set on any mismatch, cleared only by reset or start
// BEHAVIOUR
//  Reset: state=IDLE; data_out, push_out, pop_out, busy, done, sent_count, mismatch_count, err_flag all 0.
//  Reset mid-run aborts on the next edge and loses all counts.
//  FSM:
//   IDLE  -start-> GEN.
//   GEN   -sent_count==num_words-> DRAIN.
//   DRAIN -DRAIN_CYC cycles-> DONE.
//   DONE  -start-> GEN. Start in GEN or DRAIN is ignored.
//  On start: latch seed/mode/num_words; clear sent_count, mismatch_count and err_flag.
//   The next value register is loaded with seed (LFSR mode: seed==0 is replaced by 1).
//  GEN, each edge with sent_count<num_words:
//   pause_in==0 -> push_out<=1, data_out<=next, sent_count+1, advance next.
//   pause_in==1 -> push_out<=0, data_out<=0, next held.
//   Latency: pause_in takes effect on the registered push one cycle later.
//   Word sequence by mode:
//    incr: next+1, wraps modulo 2^DATA_W.
//    LFSR: shift left, LSB = ^(next & LFSR_TAPS).
//    const: next unchanged.
//    mode 3: next+1, then XOR MSB with a toggle bit that starts at 0.
//  Outside GEN: push_out=0 and data_out=0 (registered).
//  pop_out[i] = busy & ~almost_empty_in[i] (combinational); forced 0 in IDLE and DONE.
//  Compare: pop_q <= pop_out (1-cycle FIFO read latency).
//   For each i with pop_q[i]: if lane a != lane b -> mismatch_count+1 (saturating) and err_flag<=1.
//   Several mismatching lanes in one cycle add their count.
//   Comparison still runs in the cycle of the DRAIN->DONE transition.
//  Counters never wrap; sent_count <= num_words always.
// TESTING
//  reset 3 cycles -> all outputs 0, state IDLE; start during reset has no effect.
//  mode0, seed=1, num_words=10, pause_in=0 -> pushes 1..10 on 10 consecutive cycles; then done after 50 DRAIN cycles, sent_count=10.
//  mode0, pause_in high cycles 3-5 -> no push on those cycles; stream resumes with no skipped or duplicated value; sent_count=num_words.
//  mode1, seed=0, num_words=63 -> first word 1; 63 distinct non-zero values; data_out 0 only when not pushing.
//  data_a==data_b with almost_empty_in=0 -> pop_out=2'b11, mismatch_count=0; force lane1 diff 4 pop cycles -> mismatch_count=4, err_flag=1.
//  reset asserted mid-GEN after 5 pushes -> next edge push_out=0, sent_count=0; new start restarts from seed.

Source files
------------

// File: rtl/traffic_gen_checker.sv
// Traffic source/sink for the interconnect: pushes a programmable word stream into the
// main FIFO, drains the destination FIFOs and compares behavioural vs synthesized lanes.
module traffic_gen_checker #(
  parameter int                DATA_W    = 6,
  parameter int                N_DEST    = 2,
  parameter int                CNT_W     = 16,
  parameter int                DRAIN_CYC = 50,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 6'h30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [DATA_W-1:0]        seed,
  input  logic [CNT_W-1:0]         num_words,
  input  logic                     pause_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     push_out,
  input  logic [N_DEST-1:0]        almost_empty_in,
  output logic [N_DEST-1:0]        pop_out,
  input  logic [N_DEST*DATA_W-1:0] data_a,
  input  logic [N_DEST*DATA_W-1:0] data_b,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         sent_count,
  output logic [CNT_W-1:0]         mismatch_count,
  output logic                     err_flag
);

  localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [DATA_W-1:0]   next_q, next_d;
  logic                toggle_q, toggle_d;
  logic [CNT_W-1:0]    sent_q, sent_d;
  logic [CNT_W-1:0]    mism_q, mism_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                push_q, push_d;
  logic [N_DEST-1:0]   pop_q;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0]    hits_s;
  logic [CNT_W:0]      sum_s;
  logic [CNT_W-1:0]    mism_sat_s;

  // Word that follows cur in the selected stream mode.
  function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] cur,
                                                  input logic [1:0] m,
                                                  input logic tgl);
    logic [DATA_W-1:0] w;
    case (m)
      2'd0:    w = cur + DATA_W'(1);
      2'd1:    w = {cur[DATA_W-2:0], ^(cur & LFSR_TAPS)};
      2'd2:    w = cur;
      default: w = (cur + DATA_W'(1)) ^ {tgl, {(DATA_W-1){1'b0}}};
    endcase
    return w;
  endfunction

  assign busy           = (state_q == S_GEN) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign pop_out        = busy ? ~almost_empty_in : {N_DEST{1'b0}};
  assign data_out       = data_q;
  assign push_out       = push_q;
  assign sent_count     = sent_q;
  assign mismatch_count = mism_q;
  assign err_flag       = err_q;

  // Lanes popped last cycle are valid now; count the ones that disagree.
  always_comb begin
    hits_s = '0;
    for (int i = 0; i < N_DEST; i++) begin
      if (pop_q[i] && (data_a[i*DATA_W +: DATA_W] != data_b[i*DATA_W +: DATA_W])) begin
        hits_s = hits_s + CNT_W'(1);
      end else begin
        hits_s = hits_s;
      end
    end
    sum_s      = {1'b0, mism_q} + {1'b0, hits_s};
    mism_sat_s = sum_s[CNT_W] ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];
  end

  // Next-state and datapath update; a start clears the compare results it overlaps.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    num_d    = num_q;
    next_d   = next_q;
    toggle_d = toggle_q;
    sent_d   = sent_q;
    drain_d  = drain_q;
    data_d   = '0;
    push_d   = 1'b0;
    mism_d   = mism_sat_s;
    err_d    = err_q | (hits_s != '0);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = (num_words == '0) ? S_DRAIN : S_GEN;
          mode_d   = mode;
          num_d    = num_words;
          next_d   = ((mode == 2'd1) && (seed == '0)) ? DATA_W'(1) : seed;
          toggle_d = 1'b0;
          sent_d   = '0;
          drain_d  = '0;
          mism_d   = '0;
          err_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_GEN: begin
        if (sent_q == num_q) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (!pause_in) begin
          push_d   = 1'b1;
          data_d   = next_q;
          sent_d   = sent_q + CNT_W'(1);
          next_d   = next_word(next_q, mode_q, toggle_q);
          toggle_d = (mode_q == 2'd3) ? ~toggle_q : toggle_q;
        end else begin
          next_d = next_q;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRN_W'(DRAIN_CYC - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      num_q    <= '0;
      next_q   <= '0;
      toggle_q <= 1'b0;
      sent_q   <= '0;
      mism_q   <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
      push_q   <= 1'b0;
      pop_q    <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      num_q    <= num_d;
      next_q   <= next_d;
      toggle_q <= toggle_d;
      sent_q   <= sent_d;
      mism_q   <= mism_d;
      err_q    <= err_d;
      data_q   <= data_d;
      push_q   <= push_d;
      pop_q    <= pop_out;
      drain_q  <= drain_d;
    end
  end

endmodule
